// File: rtl/text_result_buffer.sv
// Circular first-word-fall-through buffer for completed result blocks, with overflow tracking.
// Optional running XOR checksum output enabled by defining TEXT_BUF_CHECKSUM_EN.
module text_result_buffer #(
  parameter int TEXT_WIDTH = 128,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = 4,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  finish_i,
  input  logic [TEXT_WIDTH-1:0] text_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  input  logic                  rd_ready_i,
  output logic                  rd_valid_o,
  output logic [TEXT_WIDTH-1:0] rd_data_o,
  output logic [TAG_WIDTH-1:0]  rd_tag_o,
  output logic [PTR_WIDTH:0]    count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  overflow_o,
  output logic [7:0]            drop_cnt_o
`ifdef TEXT_BUF_CHECKSUM_EN
  ,
  output logic [TEXT_WIDTH-1:0] checksum_o
`endif
);

  logic [TEXT_WIDTH+TAG_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0]   count;
  logic                 rd_acc, wr_acc, drop;

  assign full_o     = (count == (PTR_WIDTH+1)'(DEPTH));
  assign empty_o    = (count == '0);
  assign rd_valid_o = !empty_o;
  assign count_o    = count;
  assign {rd_data_o, rd_tag_o} = mem[rd_ptr];

  // A read in the same cycle frees the slot, so a full buffer can still accept.
  assign rd_acc = rd_valid_o && rd_ready_i;
  assign wr_acc = finish_i && (!full_o || rd_acc);
  assign drop   = finish_i && full_o && !rd_acc;

  always_ff @(posedge clk_i)
    if (wr_acc && !clear_i) mem[wr_ptr] <= {text_i, tag_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (PTR_WIDTH+1)'(1);
        2'b01:   count <= count - (PTR_WIDTH+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
      end
    end
  end

`ifdef TEXT_BUF_CHECKSUM_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        checksum_o <= '0;
    else if (clear_i) checksum_o <= '0;
    else if (wr_acc)  checksum_o <= checksum_o ^ text_i;
  end
`endif

endmodule

// File: tb/tb_text_result_buffer.sv
// Directed self-checking bench for text_result_buffer (default parameters).
module tb_text_result_buffer;
  localparam int TW = 128;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst, clear, finish, rd_ready;
  logic [TW-1:0] text;
  logic [GW-1:0] tag;
  logic          rd_valid, full, empty, overflow;
  logic [TW-1:0] rd_data;
  logic [GW-1:0] rd_tag;
  logic [4:0]    count;
  logic [7:0]    drop_cnt;
`ifdef TEXT_BUF_CHECKSUM_EN
  logic [TW-1:0] checksum;
`endif

  int vecs = 0;
  int errs = 0;

  text_result_buffer dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .finish_i(finish),
    .text_i(text), .tag_i(tag), .rd_ready_i(rd_ready),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_tag_o(rd_tag),
    .count_o(count), .full_o(full), .empty_o(empty),
    .overflow_o(overflow), .drop_cnt_o(drop_cnt)
`ifdef TEXT_BUF_CHECKSUM_EN
    , .checksum_o(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [TW-1:0] t, input logic [GW-1:0] g);
    finish = 1'b1; text = t; tag = g;
    step();
    finish = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [TW-1:0] t, input logic [GW-1:0] g);
    chk({name, "_valid"}, TW'(rd_valid), TW'(1));
    chk({name, "_data"}, rd_data, t);
    chk({name, "_tag"}, TW'(rd_tag), TW'(g));
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; finish = 1'b0; rd_ready = 1'b0; text = '0; tag = '0;
    #12;
    // reset state
    chk("rst_count", TW'(count), TW'(0));
    chk("rst_empty", TW'(empty), TW'(1));
    chk("rst_full", TW'(full), TW'(0));
    chk("rst_valid", TW'(rd_valid), TW'(0));
    chk("rst_ovf", TW'(overflow), TW'(0));
    chk("rst_drop", TW'(drop_cnt), TW'(0));
    @(negedge clk); rst = 1'b0;
    step();

    // four writes, no reads; first write visible after one cycle
    wr(TW'(1), 8'd0);
    chk("lat1_valid", TW'(rd_valid), TW'(1));
    for (int i = 1; i < 4; i++) wr(TW'(i + 1), GW'(i));
    chk("w4_count", TW'(count), TW'(4));
    chk("w4_tag", TW'(rd_tag), TW'(0));
    chk("w4_data", rd_data, TW'(1));
    for (int i = 0; i < 4; i++) pop_chk("w4_pop", TW'(i + 1), GW'(i));
    chk("w4_empty", TW'(empty), TW'(1));
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("rd_empty_noeffect", TW'(count), TW'(0));

    // fill then overflow
    for (int i = 0; i < 16; i++) wr(TW'(100 + i), GW'(16 + i));
    chk("fill_full", TW'(full), TW'(1));
    wr({16{8'hDE}}, 8'hAD);
    chk("ovf_full", TW'(full), TW'(1));
    chk("ovf_flag", TW'(overflow), TW'(1));
    chk("ovf_drop", TW'(drop_cnt), TW'(1));
    chk("ovf_count", TW'(count), TW'(16));
    for (int i = 0; i < 16; i++) pop_chk("ovf_drain", TW'(100 + i), GW'(16 + i));
    chk("ovf_drained", TW'(empty), TW'(1));
    chk("ovf_sticky", TW'(overflow), TW'(1));

    // full with simultaneous read and write
    for (int i = 0; i < 16; i++) wr(TW'(200 + i), GW'(i));
    finish = 1'b1; rd_ready = 1'b1; text = TW'(32'h999); tag = 8'h55;
    step();
    finish = 1'b0; rd_ready = 1'b0;
    chk("rw_full_count", TW'(count), TW'(16));
    chk("rw_full_head", rd_data, TW'(201));
    chk("rw_full_drop", TW'(drop_cnt), TW'(1));
    for (int i = 1; i < 16; i++) pop_chk("rw_drain", TW'(200 + i), GW'(i));
    pop_chk("rw_last", TW'(32'h999), 8'h55);

    // 40 blocks streamed through with reads always ready
    for (int i = 0; i <= 40; i++) begin
      finish = (i < 40); text = TW'(1000 + i); tag = GW'(i); rd_ready = 1'b1;
      if (i > 0) begin
        chk("stream_valid", TW'(rd_valid), TW'(1));
        chk("stream_data", rd_data, TW'(1000 + i - 1));
        chk("stream_tag", TW'(rd_tag), TW'(i - 1));
      end
      chk("stream_cnt_le1", TW'(count <= 5'd1), TW'(1));
      step();
    end
    finish = 1'b0; rd_ready = 1'b0;
    chk("stream_end_count", TW'(count), TW'(0));

    // saturating drop counter, then clear with a write in the same cycle
    for (int i = 0; i < 16; i++) wr(TW'(i), GW'(i));
    finish = 1'b1; text = TW'(7);
    for (int i = 0; i < 300; i++) step();
    chk("sat_drop", TW'(drop_cnt), TW'(255));
    chk("sat_count", TW'(count), TW'(16));
    clear = 1'b1; text = TW'(32'h777); tag = 8'h77;
    step();
    clear = 1'b0; finish = 1'b0;
    chk("clr_count", TW'(count), TW'(0));
    chk("clr_ovf", TW'(overflow), TW'(0));
    chk("clr_drop", TW'(drop_cnt), TW'(0));
    chk("clr_empty", TW'(empty), TW'(1));
`ifdef TEXT_BUF_CHECKSUM_EN
    chk("clr_csum", checksum, TW'(0));
`endif

    // reset mid-operation discards entries; next write lands at entry 0
    for (int i = 0; i < 3; i++) wr(TW'(50 + i), GW'(i));
    rst = 1'b1; #1;
    chk("mid_rst_count", TW'(count), TW'(0));
    chk("mid_rst_valid", TW'(rd_valid), TW'(0));
    @(negedge clk); rst = 1'b0;
    step();
    wr(TW'(32'hABC), 8'h3C);
    chk("post_rst_count", TW'(count), TW'(1));
    chk("post_rst_data", rd_data, TW'(32'hABC));
    chk("post_rst_entry0", dut.mem[0], {TW'(32'hABC), 8'h3C});
    rd_ready = 1'b1; step(); rd_ready = 1'b0;

`ifdef TEXT_BUF_CHECKSUM_EN
    rst = 1'b1; #1;
    chk("csum_rst", checksum, TW'(0));
    @(negedge clk); rst = 1'b0;
    step();
    wr({16{8'h0F}}, 8'd1);
    wr({16{8'hF0}}, 8'd2);
    chk("csum_ff", checksum, {16{8'hFF}});
    rst = 1'b1; #1;
    chk("csum_after_rst", checksum, TW'(0));
    @(negedge clk); rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
